pooling_ctrl: RTL

- Sequencer for the 2x2 max-pooling engine (POOLING).
- Accepts a start command and a valid-qualified stream of N*N convolution outputs, which may contain idle gaps.
- Drives the engine's en_reg / en_pooling / conv_out inputs and watches done_pooling.
- Writes each pooled result into the feature-map buffer at base + addr, then reports completion or a timeout error.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/pooling_watchdog.sv | 39 +++
 rtl/pooling_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and sizing for the pooling sequencer and the 2x2 max-pooling engine.
package cnn_pkg;

   localparam int N_DEF  = 8;
   localparam int DW_DEF = 16;
   localparam int AW_DEF = 16;
   localparam int NSAMP  = N_DEF * N_DEF;
   localparam int NPOOL  = (N_DEF / 2) * (N_DEF / 2);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_POOL   = 3'd3,
      ST_FIN    = 3'd4
   } state_e;

   function automatic int nsamp_of(input int n);
      return n * n;
   endfunction

endpackage

// File: rtl/pooling_watchdog.sv
// Loadable down-counter; expire_o flags the last permitted decrementing cycle.
module pooling_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load_i,
   input  logic dec_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // next count: reload, or step down while armed
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(TIMEOUT);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = dec_i && (cnt_q == CW'(1));

endmodule

// File: rtl/pooling_ctrl.sv
// Sequencer for the 2x2 max-pooling engine: loads N*N samples, runs pooling,
// writes pooled results to base+addr and reports done or a timeout error.
module pooling_ctrl
   import cnn_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int DW      = DW_DEF,
   parameter int AW      = AW_DEF,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] out_base,
   input  logic          conv_valid,
   input  logic [DW-1:0] conv_data,
   output logic          en_reg,
   output logic          en_pooling,
   output logic [DW-1:0] conv_out,
   input  logic [DW-1:0] pooling_out,
   input  logic [AW-1:0] addr,
   input  logic          done_pooling,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int NS  = nsamp_of(N);
   localparam int SCW = $clog2(NS + 1);

   state_e        state_q, state_d;
   logic [SCW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] base_q, base_d;
   logic          en_reg_q, en_reg_d;
   logic          en_pool_q, en_pool_d;
   logic [DW-1:0] conv_out_q, conv_out_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          wd_load_s, wd_dec_s, wd_expire_s;

   pooling_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (wd_load_s),
      .dec_i    (wd_dec_s),
      .expire_o (wd_expire_s)
   );

   // next-state and registered-output decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      base_d     = base_q;
      en_reg_d   = 1'b0;
      conv_out_d = conv_out_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      err_d      = err_q;
      wd_load_s  = 1'b0;
      wd_dec_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = out_base;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (conv_valid) begin
               en_reg_d   = 1'b1;
               conv_out_d = conv_data;
               cnt_d      = cnt_q + SCW'(1);
               if (cnt_q == SCW'(NS - 1)) begin
                  state_d = ST_SETTLE;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_SETTLE: begin
            wd_load_s = 1'b1;
            state_d   = ST_POOL;
         end
         ST_POOL: begin
            wd_dec_s = 1'b1;
            if (done_pooling) begin
               state_d = ST_FIN;
            end else begin
               wr_en_d   = 1'b1;
               wr_data_d = pooling_out;
               wr_addr_d = base_q + addr;
               // a timed-out frame still forwards its final engine output
               if (wd_expire_s) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_POOL;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      en_pool_d = (state_d == ST_POOL);
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_FIN);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         base_q     <= '0;
         en_reg_q   <= 1'b0;
         en_pool_q  <= 1'b0;
         conv_out_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         en_reg_q   <= en_reg_d;
         en_pool_q  <= en_pool_d;
         conv_out_q <= conv_out_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign en_reg     = en_reg_q;
   assign en_pooling = en_pool_q;
   assign conv_out   = conv_out_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
